// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and default width.
package serial_subtractor_pkg;

  localparam int unsigned DefaultWidth = 8;

  // FSM encodings; 2'd3 is unused and recovers to StIdle
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module serial_subtractor_full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
  logic             bin_q, bin_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic bit_d, bit_bout;

  serial_subtractor_full_sub u_full_sub (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (bin_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Next-state: accept in IDLE/DONE, shift one bit per cycle, publish results on the last bit
  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    sr_d       = sr_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = {bit_d, sr_q[WIDTH-1:1]};
        bin_d = bit_bout;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Results are registered on the final shift so they line up with done
          state_d    = StDone;
          diff_d     = {bit_d, sr_q[WIDTH-1:1]};
          borrow_d   = bit_bout;
          overflow_d = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset that abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sa_q       <= '0;
      sb_q       <= '0;
      sr_q       <= '0;
      bin_q      <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      sr_q       <= sr_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == StShift);
  assign done     = (state_q == StDone);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle model plus directed literal checks.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, borrow, overflow;
  logic [7:0] diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining shift cycles and the arithmetic result of the accepted operands
  int         m_remain = 0;
  bit         m_done = 0;
  logic [7:0] m_pa, m_pb;
  logic [7:0] m_diff = '0;
  bit         m_borrow = 0, m_ovf = 0;
  bit         m_valid = 0;

  always @(posedge clk) begin
    int sd;
    m_valid = 1;
    if (reset) begin
      m_remain = 0; m_done = 0; m_diff = '0; m_borrow = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          m_done   = 1;
          m_diff   = m_pa - m_pb;
          m_borrow = (m_pa < m_pb);
          sd       = int'($signed(m_pa)) - int'($signed(m_pb));
          m_ovf    = (sd > 127) || (sd < -128);
        end
      end else if (start) begin
        m_pa = a; m_pb = b; m_remain = 8;
      end
    end
  end

  // Compare DUT with the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_remain > 0));
      check("done", 32'(done), 32'(m_done));
      check("diff", 32'(diff), 32'(m_diff));
      check("borrow", 32'(borrow), 32'(m_borrow));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // One operation with hand-computed expectations, including latency and busy length
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] ed,
                       input bit eb, input bit eo, input string name);
    int k = 0;
    int nbusy = 0;
    bit seen = 0;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    while (!seen && k < 30) begin
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      k++;
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, k, 9);
    check({name, "_busy_cycles"}, nbusy, 8);
    check({name, "_diff"}, 32'(diff), 32'(ed));
    check({name, "_borrow"}, 32'(borrow), 32'(eb));
    check({name, "_overflow"}, 32'(overflow), 32'(eo));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int ndone;
    int t_first, t_second;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    reset = 1'b0;

    do_op(8'h57, 8'h01, 8'h56, 0, 0, "t1");
    do_op(8'h00, 8'h57, 8'hA9, 1, 0, "t2");
    do_op(8'h80, 8'h01, 8'h7F, 0, 1, "t3a");
    do_op(8'h01, 8'h02, 8'hFF, 1, 0, "t3b");
    do_op(8'h35, 8'h00, 8'h35, 0, 0, "a_minus_0");
    idle(2);

    // Second start while busy is ignored: one done, diff 03
    @(negedge clk);
    a = 8'h0A; b = 8'h07; start = 1'b1;
    @(negedge clk); start = 1'b0;
    idle(2);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("t4_diff", 32'(diff), 32'h03);
      end
    end
    check("t4_done_count", ndone, 1);

    // Reset mid-operation abandons it
    @(negedge clk);
    a = 8'h44; b = 8'h11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_diff", 32'(diff), 32'd0);
    check("t5_borrow", 32'(borrow), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_no_done", ndone, 0);
    do_op(8'h07, 8'h05, 8'h02, 0, 0, "t5b");
    idle(2);

    // Start held through DONE: back-to-back, done pulses 9 cycles apart
    @(negedge clk);
    a = 8'h10; b = 8'h03; start = 1'b1;
    ndone = 0; t_first = 0; t_second = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) t_first = i;
        if (ndone == 2) t_second = i;
        check("t6_diff", 32'(diff), 32'h0D);
      end
    end
    check("t6_done_count", ndone, 2);
    check("t6_spacing", t_second - t_first, 9);

    // Randomised traffic against the model, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
